// File: rtl/bit_set_sequencer.sv
// -----------------------------------------------------------------------------
// bit_set_sequencer
//   Sequential controller around an external combinational bit-setting stage.
//   A stream of sign-magnitude bit indices is accepted through a valid/ready
//   handshake. For each accepted index, the accumulated mask (o_a) and the
//   index (o_b) are presented to the stage. Its result (i_out/i_err) is
//   registered in the same cycle. The last index ends the sequence with a
//   one-cycle o_done pulse, and the final mask is then held on o_mask.
//
// Ports
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_start, i_init      begin a sequence (IDLE only) with an initial mask
//   i_b_valid, i_b       index stream; i_last marks the final index
//   o_b_ready            high in ACCUM only
//   o_a, o_b             operands to the bit-setting stage
//   i_out, i_err         result/error from the bit-setting stage
//   o_mask, o_done       accumulated mask, end-of-sequence pulse
//   o_ops_cnt, o_err_cnt saturating counts of applied / rejected indices
// -----------------------------------------------------------------------------
module bit_set_sequencer #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_start,
    input  logic [N-1:0]  i_init,
    input  logic          i_b_valid,
    input  logic [N-1:0]  i_b,
    input  logic          i_last,
    output logic          o_b_ready,
    output logic [N-1:0]  o_a,
    output logic [N-1:0]  o_b,
    input  logic [N-1:0]  i_out,
    input  logic          i_err,
    output logic [N-1:0]  o_mask,
    output logic          o_done,
    output logic [CW-1:0] o_ops_cnt,
    output logic [CW-1:0] o_err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_e        state_q, state_d;
    logic [N-1:0]  mask_q,  mask_d;
    logic [CW-1:0] ops_q,   ops_d;
    logic [CW-1:0] err_q,   err_d;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            ops_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ops_q   <= ops_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        ops_d     = ops_q;
        err_d     = err_q;
        o_b_ready = 1'b0;
        o_done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    mask_d  = i_init;
                    ops_d   = '0;
                    err_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                o_b_ready = 1'b1;
                // i_out/i_err are meaningful only on a handshake cycle.
                if (i_b_valid) begin
                    if (!i_err) begin
                        mask_d = i_out;
                        if (ops_q != CNT_MAX) ops_d = ops_q + 1'b1;
                    end else begin
                        if (err_q != CNT_MAX) err_d = err_q + 1'b1;
                    end
                    // A rejected last index still ends the sequence.
                    if (i_last) state_d = S_DONE;
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_a       = mask_q;
    assign o_b       = i_b;
    assign o_mask    = mask_q;
    assign o_ops_cnt = ops_q;
    assign o_err_cnt = err_q;

endmodule

// File: tb/tb_bit_set_sequencer.sv
module tb_bit_set_sequencer;
    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start, b_valid, last;
    logic [N-1:0]  init, b;
    logic          b_ready, done, st_err;
    logic [N-1:0]  a, ob, st_out, mask;
    logic [CW-1:0] ops_cnt, err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Reference bit-setting stage: reject a negative index or a magnitude > N.
    // A magnitude of N shifts the one-hot bit out, so the mask is unchanged.
    logic [N-2:0] mag;
    logic [N-1:0] onehot;
    assign mag    = ob[N-2:0];
    assign onehot = (mag < N) ? (N'(1) << mag) : '0;
    assign st_err = ob[N-1] | (mag > N);
    assign st_out = a | onehot;

    bit_set_sequencer #(.N(N), .CW(CW)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_init(init),
        .i_b_valid(b_valid), .i_b(b), .i_last(last), .o_b_ready(b_ready),
        .o_a(a), .o_b(ob), .i_out(st_out), .i_err(st_err), .o_mask(mask),
        .o_done(done), .o_ops_cnt(ops_cnt), .o_err_cnt(err_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_seq(input logic [N-1:0] iv);
        init = iv; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [N-1:0] idx, input logic l);
        b_valid = 1'b1; b = idx; last = l;
        tick();
        b_valid = 1'b0; last = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; init = '0; b_valid = 1'b0; b = '0; last = 1'b0;
        tick(); tick();
        n_cmp++; if (mask !== 8'h00)  begin n_bad++; $display("FAIL reset_mask got=%h exp=00", mask); end
        n_cmp++; if (done !== 1'b0)   begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (ops_cnt !== 4'd0 || err_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", ops_cnt, err_cnt); end
        n_cmp++; if (b_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b exp=0", b_ready); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        begin_seq(8'h00);
        n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_rise got=%b exp=1", b_ready); end
        send(8'd0, 1'b0);
        n_cmp++; if (mask !== 8'h01 || a !== 8'h01) begin n_bad++; $display("FAIL basic_idx0 got=%h/%h exp=01", mask, a); end
        send(8'd3, 1'b0);
        n_cmp++; if (mask !== 8'h09) begin n_bad++; $display("FAIL basic_idx3 got=%h exp=09", mask); end
        n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("FAIL basic_early_done got=%b exp=0", done); end
        send(8'd7, 1'b1);
        n_cmp++; if (mask !== 8'h89 || done !== 1'b1) begin n_bad++; $display("FAIL basic_final got=%h done=%b exp=89 done=1", mask, done); end
        tick();
        n_cmp++; if (done !== 1'b0 || b_ready !== 1'b0) begin n_bad++; $display("FAIL basic_pulse_end got=done%b rdy%b exp=0/0", done, b_ready); end
        n_cmp++; if (mask !== 8'h89 || ops_cnt !== 4'd3 || err_cnt !== 4'd0) begin n_bad++; $display("FAIL basic_hold got=%h %0d/%0d exp=89 3/0", mask, ops_cnt, err_cnt); end
    endtask

    task automatic test_errors();
        begin_seq(8'h10);
        n_cmp++; if (mask !== 8'h10 || ops_cnt !== 4'd0) begin n_bad++; $display("FAIL err_load got=%h %0d exp=10 0", mask, ops_cnt); end
        send(8'h81, 1'b0);
        n_cmp++; if (mask !== 8'h10 || err_cnt !== 4'd1) begin n_bad++; $display("FAIL err_neg got=%h %0d exp=10 1", mask, err_cnt); end
        send(8'd9, 1'b0);
        send(8'd2, 1'b1);
        n_cmp++; if (mask !== 8'h14 || ops_cnt !== 4'd1 || err_cnt !== 4'd2 || done !== 1'b1) begin n_bad++; $display("FAIL err_final got=%h %0d/%0d d=%b exp=14 1/2 d=1", mask, ops_cnt, err_cnt, done); end
        tick();
    endtask

    task automatic test_boundaries();
        begin_seq(8'h01);
        send(8'd8, 1'b1);
        n_cmp++; if (mask !== 8'h01 || ops_cnt !== 4'd1 || err_cnt !== 4'd0) begin n_bad++; $display("FAIL bnd_mag_n got=%h %0d/%0d exp=01 1/0", mask, ops_cnt, err_cnt); end
        tick();
        begin_seq(8'h00);
        send(8'h80, 1'b1);
        n_cmp++; if (mask !== 8'h00 || ops_cnt !== 4'd0 || err_cnt !== 4'd1 || done !== 1'b1) begin n_bad++; $display("FAIL bnd_neg0 got=%h %0d/%0d d=%b exp=00 0/1 d=1", mask, ops_cnt, err_cnt, done); end
        tick();
    endtask

    task automatic test_gaps();
        begin_seq(8'h00);
        send(8'd1, 1'b0);
        b = 8'd5;           // index present but not valid
        tick();
        n_cmp++; if (mask !== 8'h02 || ops_cnt !== 4'd1) begin n_bad++; $display("FAIL gap_idle got=%h %0d exp=02 1", mask, ops_cnt); end
        init = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (mask !== 8'h02) begin n_bad++; $display("FAIL gap_start_accum got=%h exp=02", mask); end
        send(8'd4, 1'b1);
        n_cmp++; if (mask !== 8'h12 || ops_cnt !== 4'd2) begin n_bad++; $display("FAIL gap_final got=%h %0d exp=12 2", mask, ops_cnt); end
        tick();
        // Index offered in IDLE is dropped.
        b_valid = 1'b1; b = 8'd3; #1;
        n_cmp++; if (b_ready !== 1'b0 || ob !== 8'd3) begin n_bad++; $display("FAIL idle_ready got=rdy%b ob%h exp=0 03", b_ready, ob); end
        tick();
        b_valid = 1'b0;
        n_cmp++; if (mask !== 8'h12 || ops_cnt !== 4'd2 || b_ready !== 1'b0) begin n_bad++; $display("FAIL idle_drop got=%h %0d rdy%b exp=12 2 0", mask, ops_cnt, b_ready); end
    endtask

    task automatic test_saturation();
        begin_seq(8'h00);
        for (int i = 0; i < 15; i++) send(8'd1, 1'b0);
        n_cmp++; if (ops_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_reach got=%0d exp=15", ops_cnt); end
        for (int i = 0; i < 5; i++) send(8'd1, 1'b0);
        send(8'd1, 1'b1);
        n_cmp++; if (ops_cnt !== 4'd15 || mask !== 8'h02 || err_cnt !== 4'd0) begin n_bad++; $display("FAIL sat_hold got=%0d %h %0d exp=15 02 0", ops_cnt, mask, err_cnt); end
        tick();
    endtask

    task automatic test_back_to_back_reset();
        begin_seq(8'h00);
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        n_cmp++; if (mask !== 8'h06) begin n_bad++; $display("FAIL rst_pre got=%h exp=06", mask); end
        #2 rstn = 1'b0;
        #1;
        n_cmp++; if (mask !== 8'h00 || ops_cnt !== 4'd0 || err_cnt !== 4'd0 || b_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid got=%h %0d/%0d rdy%b exp=00 0/0 0", mask, ops_cnt, err_cnt, b_ready); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_no_done got=%b exp=0", done); end
        rstn = 1'b1;
        tick();
        begin_seq(8'h40);
        send(8'd0, 1'b1);
        n_cmp++; if (mask !== 8'h41 || ops_cnt !== 4'd1 || done !== 1'b1) begin n_bad++; $display("FAIL rst_after got=%h %0d d=%b exp=41 1 d=1", mask, ops_cnt, done); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_boundaries();
        test_gaps();
        test_saturation();
        test_back_to_back_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bit_set_sequencer.md
# bit_set_sequencer

Sequential controller wrapped around the bit-setting stage. It accepts a stream of bit indices through a valid/ready handshake and feeds the accumulated mask and current index to the bit-setting stage as its A and B operands. It registers each returned result as the new accumulated mask and counts accepted and rejected indices. On the last index it presents the final mask with a one-cycle done pulse.

## Interface
- N, 8, operand/mask width; must match N of the bit-setting stage.
- CW, 4, width of the operation and error counters.

- i_clk  in  1  system clock, all state on rising edge
- i_rstn  in  1  asynchronous reset, active-low
- i_start  in  1  begin new sequence; sampled only in IDLE
- i_init  in  N  initial mask value loaded on accepted i_start
- i_b_valid  in  1  index present on i_b
- i_b  in  N  bit index, sign-magnitude: bit N-1 sign, bits N-2:0 magnitude
- i_last  in  1  qualifies the current index as the final one of the sequence
- o_b_ready  out  1  sequencer can accept an index
- o_a  out  N  current accumulated mask, to the bit-setting stage's A input
- o_b  out  N  index to the bit-setting stage's B input
- i_out  in  N  result returned by the bit-setting stage
- i_err  in  1  error flag returned by the bit-setting stage
- o_mask  out  N  accumulated mask register
- o_done  out  1  one-cycle pulse, final mask valid on o_mask
- o_ops_cnt  out  CW  indices applied without error, saturating
- o_err_cnt  out  CW  indices rejected by the bit-setting stage, saturating

## Operation
- Reset values (asynchronous, active-low):
  - state = IDLE
  - o_mask = 0
  - o_done = 0
  - o_ops_cnt = 0
  - o_err_cnt = 0
  - o_b_ready = 0
- The state machine has three states:
  - IDLE:
    - o_b_ready = 0.
    - i_start = 1 loads the mask register with i_init, clears both counters and moves to ACCUM.
  - ACCUM:
    - o_b_ready = 1.
    - A handshake occurs when i_b_valid & o_b_ready.
    - i_start is ignored.
  - DONE:
    - o_done = 1 for exactly this one cycle.
    - Moves unconditionally to IDLE.
    - i_start is ignored.
- On each handshake:
  - If i_err = 0: mask register <= i_out and o_ops_cnt increments.
  - If i_err = 1: mask register is unchanged and o_err_cnt increments.
  - If i_last = 1 with the handshake: next state is DONE. A failed last index still ends the sequence.
- Counters saturate at all-ones and never wrap.
- Mask register drive:
  - o_mask holds its value in IDLE after DONE until the next accepted i_start.
  - o_a always equals the mask register.
- o_b = i_b combinationally in every state. i_out/i_err are only sampled on a handshake.
- The bit-setting stage rejects negative indices and magnitude > N.
  - Magnitude = N is accepted, but 1<<N truncates to zero.
  - For that index the mask is unchanged and o_ops_cnt still increments.
- i_b_valid with o_b_ready = 0 (IDLE/DONE) is dropped. No buffering.

## Timing
- The path i_b -> o_b -> bit-setting stage -> i_out/i_err -> mask register D is fully combinational within one cycle.
- One index is accepted per cycle in ACCUM, giving a sustained throughput of 1/cycle.
- Latency:
  - The mask update is visible on o_mask and o_a the cycle after the handshake.
  - o_done is high the cycle after the last handshake, coincident with the final o_mask.
- Minimum sequence, start to done, is 3 cycles: i_start cycle, one ACCUM handshake with i_last, then DONE.
- Asserting reset mid-sequence returns the block to IDLE immediately and clears all registers. No done pulse is produced.
- Any partial mask is lost on reset.
- After i_start in IDLE, o_b_ready rises the next cycle.

## Test plan
- Basic sequence: reset, i_init=0x00, i_start, then indices 0, 3, 7 (last on 7), back-to-back -> o_mask=0x89, o_done pulse one cycle later than the index-7 handshake, o_ops_cnt=3, o_err_cnt=0.
- Errors: i_init=0x10, indices 0x81 (negative), 9, 2 (last) -> o_mask=0x14, o_ops_cnt=1, o_err_cnt=2.
- Boundaries: i_init=0x01, index 8 (last) -> o_mask=0x01, o_ops_cnt=1, o_err_cnt=0. Separately, index 0x80 (sign set, magnitude 0) -> error counted.
- Handshake gaps and gating:
  - i_b_valid toggling with idle cycles gives no update on idle cycles.
  - i_b_valid asserted in IDLE is ignored and o_b_ready stays 0.
  - i_start during ACCUM does not reload the mask.
- Saturation: CW=4, 20 valid indices of 1 then last -> o_ops_cnt=15 (no wrap), o_mask=0x02.
- Reset mid-ACCUM after indices 1 and 2 (mask 0x06): pulling i_rstn low gives o_mask=0, counters 0 and state IDLE immediately. No o_done. The next sequence operates normally from i_init.
